// File: rtl/route_seq_ctrl.sv
// Round-robin routing-profile scheduler for TOP with break-before-make guard and outFIFO read gating.
// Optional build macro ROUTE_SEQ_DWELL_HOLD_EN: dwell counts serviced reads instead of ACTIVE cycles.
module route_seq_ctrl #(
  parameter int N_PROFILES   = 4,
  parameter int DWELL_W      = 8,
  parameter int GUARD_CYCLES = 2,
  localparam int AW          = $clog2(N_PROFILES)
) (
  input  logic               inClock,
  input  logic               inReset,
  input  logic               inCfgWrite,
  input  logic [AW-1:0]      inCfgAddr,
  input  logic [16:0]        inCfgData,
  input  logic [DWELL_W-1:0] inCfgDwell,
  input  logic [AW-1:0]      inLastIdx,
  input  logic               inStart,
  input  logic               inStop,
  input  logic               inFifoEmpty,
  output logic [16:0]        outSelect,
  output logic               outReadEnable,
  output logic               outBusy,
  output logic [AW-1:0]      outProfileIdx,
  output logic               outSwitchPulse,
  output logic               outCfgErr
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_t;

  state_t             state, state_nx;
  logic [16:0]        slot_sel   [N_PROFILES];
  logic [DWELL_W-1:0] slot_dwell [N_PROFILES];
  logic [AW-1:0]      idx, last_idx, idx_wrap;
  logic [GW-1:0]      gcnt;
  logic [DWELL_W-1:0] dcnt;
  logic [16:0]        sel;
  logic               pulse, cfg_err;
  logic               dwell_tick, dwell_done, guard_done;
  logic               start_go, switch_go, load_dwell;
  logic               cfg_ok, cfg_rej, read_en;

`ifdef ROUTE_SEQ_DWELL_HOLD_EN
  assign dwell_tick = ~inFifoEmpty;
`else
  assign dwell_tick = 1'b1;
`endif

  assign dwell_done = (dcnt == DWELL_W'(1)) && dwell_tick;
  assign guard_done = (gcnt == GW'(GUARD_CYCLES - 1));
  assign idx_wrap   = (idx == last_idx) ? '0 : idx + 1'b1;

  always_comb begin
    state_nx   = state;
    start_go   = 1'b0;
    switch_go  = 1'b0;
    load_dwell = 1'b0;
    if (inStop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (inStart) begin
          state_nx = GUARD;
          start_go = 1'b1;
        end
        GUARD: if (guard_done) begin
          state_nx   = ACTIVE;
          load_dwell = 1'b1;
        end
        ACTIVE: if (dwell_done) begin
          state_nx  = GUARD;
          switch_go = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // A write aimed at the slot being switched to this cycle is treated as hitting the live slot.
  always_comb begin
    cfg_ok  = 1'b0;
    cfg_rej = 1'b0;
    if (inCfgWrite) begin
      if (state == IDLE)
        cfg_ok = 1'b1;
      else if ((inCfgAddr != idx) && !(switch_go && (inCfgAddr == idx_wrap)))
        cfg_ok = 1'b1;
      else
        cfg_rej = 1'b1;
    end
  end

  assign read_en = (state == ACTIVE) && !inFifoEmpty && !inStop;

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      gcnt     <= '0;
      dcnt     <= '0;
      sel      <= '0;
      pulse    <= 1'b0;
      cfg_err  <= 1'b0;
      for (int i = 0; i < N_PROFILES; i++) begin
        slot_sel[i]   <= '0;
        slot_dwell[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      pulse   <= start_go | switch_go;
      cfg_err <= cfg_rej;

      if (start_go) begin
        idx      <= '0;
        sel      <= slot_sel[0];
        last_idx <= inLastIdx;
        gcnt     <= '0;
      end else if (switch_go) begin
        idx  <= idx_wrap;
        sel  <= slot_sel[idx_wrap];
        gcnt <= '0;
        if (idx == last_idx)
          last_idx <= inLastIdx;
      end else if ((state == GUARD) && !guard_done) begin
        gcnt <= gcnt + 1'b1;
      end

      // Zero dwell still gives the slot one ACTIVE cycle.
      if (load_dwell)
        dcnt <= (slot_dwell[idx] == '0) ? DWELL_W'(1) : slot_dwell[idx];
      else if ((state == ACTIVE) && dwell_tick && !dwell_done)
        dcnt <= dcnt - 1'b1;

      if (cfg_ok) begin
        slot_sel[inCfgAddr]   <= inCfgData;
        slot_dwell[inCfgAddr] <= inCfgDwell;
      end
    end
  end

  assign outSelect      = sel;
  assign outReadEnable  = read_en;
  assign outBusy        = (state != IDLE);
  assign outProfileIdx  = idx;
  assign outSwitchPulse = pulse;
  assign outCfgErr      = cfg_err;

endmodule

// File: tb/tb_route_seq_ctrl.sv
// Bench for route_seq_ctrl: directed vector table, hand sequences and a randomized reference-model run.
module tb_route_seq_ctrl;
  localparam int N_PROFILES   = 4;
  localparam int DWELL_W      = 8;
  localparam int GUARD_CYCLES = 2;
  localparam int AW           = 2;
`ifdef ROUTE_SEQ_DWELL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic               inClock = 1'b0;
  logic               inReset;
  logic               inCfgWrite;
  logic [AW-1:0]      inCfgAddr;
  logic [16:0]        inCfgData;
  logic [DWELL_W-1:0] inCfgDwell;
  logic [AW-1:0]      inLastIdx;
  logic               inStart;
  logic               inStop;
  logic               inFifoEmpty;
  logic [16:0]        outSelect;
  logic               outReadEnable;
  logic               outBusy;
  logic [AW-1:0]      outProfileIdx;
  logic               outSwitchPulse;
  logic               outCfgErr;

  route_seq_ctrl #(
    .N_PROFILES(N_PROFILES), .DWELL_W(DWELL_W), .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .inClock(inClock), .inReset(inReset), .inCfgWrite(inCfgWrite), .inCfgAddr(inCfgAddr),
    .inCfgData(inCfgData), .inCfgDwell(inCfgDwell), .inLastIdx(inLastIdx), .inStart(inStart),
    .inStop(inStop), .inFifoEmpty(inFifoEmpty), .outSelect(outSelect),
    .outReadEnable(outReadEnable), .outBusy(outBusy), .outProfileIdx(outProfileIdx),
    .outSwitchPulse(outSwitchPulse), .outCfgErr(outCfgErr)
  );

  always #5 inClock = ~inClock;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        start, stop, wr;
    logic [1:0]  addr;
    logic [16:0] data;
    logic [7:0]  dwell;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [33];

  // Reference model state
  logic [16:0] m_slot  [N_PROFILES];
  logic [7:0]  m_dwell [N_PROFILES];
  bit          m_busy, m_pulse, m_err;
  int          m_gl, m_al, m_idx, m_last;
  logic [16:0] m_sel;

  function automatic logic [31:0] mkexp(input logic [16:0] s, input logic re, input logic b,
                                        input logic [1:0] i, input logic p, input logic e);
    return {9'd0, s, re, b, i, p, e};
  endfunction

  function automatic logic [31:0] pack_out();
    return mkexp(outSelect, outReadEnable, outBusy, outProfileIdx, outSwitchPulse, outCfgErr);
  endfunction

  function automatic vec_t mkv(input logic st, input logic sp, input logic w, input logic [1:0] a,
                               input logic [16:0] d, input logic [7:0] dw, input logic [31:0] e);
    vec_t v;
    v.start = st; v.stop = sp; v.wr = w; v.addr = a; v.data = d; v.dwell = dw; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge inClock);
    #1;
  endtask

  task automatic quiet_inputs();
    inCfgWrite = 0; inCfgAddr = 0; inCfgData = 0; inCfgDwell = 0;
    inLastIdx = 0; inStart = 0; inStop = 0; inFifoEmpty = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_PROFILES; i++) begin
      m_slot[i] = 0;
      m_dwell[i] = 0;
    end
    m_busy = 0; m_pulse = 0; m_err = 0; m_gl = 0; m_al = 0; m_idx = 0; m_last = 0; m_sel = 0;
  endtask

  function automatic logic [31:0] model_exp();
    logic re;
    re = m_busy && (m_gl == 0) && !inFifoEmpty && !inStop;
    return mkexp(m_sel, re, m_busy, 2'(m_idx), m_pulse, m_err);
  endfunction

  // Slot advance and guard/dwell bookkeeping from the remaining-cycle counts.
  task automatic model_step();
    bit tick, ending, acc, np, ne;
    int nxt;
    tick   = HOLD ? !inFifoEmpty : 1'b1;
    ending = m_busy && (m_gl == 0) && (m_al == 1) && tick;
    nxt    = (m_idx == m_last) ? 0 : m_idx + 1;
    acc    = inCfgWrite && (!m_busy ||
             ((int'(inCfgAddr) != m_idx) && !(ending && !inStop && int'(inCfgAddr) == nxt)));
    ne = inCfgWrite && !acc;
    np = 0;
    if (inStop) begin
      m_busy = 0; m_gl = 0;
    end else if (!m_busy) begin
      if (inStart) begin
        m_busy = 1; m_idx = 0; m_sel = m_slot[0]; m_last = int'(inLastIdx);
        m_gl = GUARD_CYCLES; np = 1;
      end
    end else if (m_gl > 0) begin
      m_gl--;
      if (m_gl == 0) m_al = (m_dwell[m_idx] == 0) ? 1 : int'(m_dwell[m_idx]);
    end else if (ending) begin
      if (nxt == 0) m_last = int'(inLastIdx);
      m_idx = nxt; m_sel = m_slot[nxt]; m_gl = GUARD_CYCLES; np = 1;
    end else if (tick) begin
      m_al--;
    end
    if (acc) begin
      m_slot[inCfgAddr]  = inCfgData;
      m_dwell[inCfgAddr] = inCfgDwell;
    end
    m_pulse = np; m_err = ne;
  endtask

  initial begin
    int period;
    int chg_cyc;
    logic [16:0] prev_sel;

    // Slots 0..2 = 1/2/4, dwell 3/1/0, lastIdx 2, FIFO never empty.
    tbl[0]  = mkv(0,0,1,0,17'h00001,3, mkexp(0,0,0,0,0,0));
    tbl[1]  = mkv(0,0,1,1,17'h00002,1, mkexp(0,0,0,0,0,0));
    tbl[2]  = mkv(0,0,1,2,17'h00004,0, mkexp(0,0,0,0,0,0));
    tbl[3]  = mkv(1,0,0,0,0,0,         mkexp(0,0,0,0,0,0));
    tbl[4]  = mkv(0,0,0,0,0,0,         mkexp(1,0,1,0,1,0));
    tbl[5]  = mkv(0,0,0,0,0,0,         mkexp(1,0,1,0,0,0));
    tbl[6]  = mkv(0,0,0,0,0,0,         mkexp(1,1,1,0,0,0));
    tbl[7]  = mkv(0,0,0,0,0,0,         mkexp(1,1,1,0,0,0));
    tbl[8]  = mkv(0,0,0,0,0,0,         mkexp(1,1,1,0,0,0));
    tbl[9]  = mkv(0,0,0,0,0,0,         mkexp(2,0,1,1,1,0));
    tbl[10] = mkv(0,0,0,0,0,0,         mkexp(2,0,1,1,0,0));
    tbl[11] = mkv(0,0,0,0,0,0,         mkexp(2,1,1,1,0,0));
    tbl[12] = mkv(0,0,0,0,0,0,         mkexp(4,0,1,2,1,0));
    tbl[13] = mkv(0,0,0,0,0,0,         mkexp(4,0,1,2,0,0));
    tbl[14] = mkv(0,0,0,0,0,0,         mkexp(4,1,1,2,0,0));
    tbl[15] = mkv(0,0,0,0,0,0,         mkexp(1,0,1,0,1,0));
    tbl[16] = mkv(0,0,0,0,0,0,         mkexp(1,0,1,0,0,0));
    tbl[17] = mkv(0,0,0,0,0,0,         mkexp(1,1,1,0,0,0));
    tbl[18] = mkv(0,0,1,0,17'h1FFFF,9, mkexp(1,1,1,0,0,0));
    tbl[19] = mkv(0,0,1,2,17'h00008,2, mkexp(1,1,1,0,0,1));
    tbl[20] = mkv(0,0,1,1,17'h00010,5, mkexp(2,0,1,1,1,0));
    tbl[21] = mkv(0,0,0,0,0,0,         mkexp(2,0,1,1,0,1));
    tbl[22] = mkv(0,0,1,2,17'h1FFFF,7, mkexp(2,1,1,1,0,0));
    tbl[23] = mkv(0,0,0,0,0,0,         mkexp(8,0,1,2,1,1));
    tbl[24] = mkv(0,0,0,0,0,0,         mkexp(8,0,1,2,0,0));
    tbl[25] = mkv(0,0,0,0,0,0,         mkexp(8,1,1,2,0,0));
    tbl[26] = mkv(0,1,0,0,0,0,         mkexp(8,0,1,2,0,0));
    tbl[27] = mkv(0,0,0,0,0,0,         mkexp(8,0,0,2,0,0));
    tbl[28] = mkv(1,1,0,0,0,0,         mkexp(8,0,0,2,0,0));
    tbl[29] = mkv(1,0,0,0,0,0,         mkexp(8,0,0,2,0,0));
    tbl[30] = mkv(0,0,0,0,0,0,         mkexp(1,0,1,0,1,0));
    tbl[31] = mkv(0,1,0,0,0,0,         mkexp(1,0,1,0,0,0));
    tbl[32] = mkv(0,0,0,0,0,0,         mkexp(1,0,0,0,0,0));

    // Reset held while inputs toggle
    quiet_inputs();
    inReset = 0;
    #1;
    for (int i = 0; i < 6; i++) begin
      inStart = 1'($urandom); inStop = 1'($urandom); inCfgWrite = 1'($urandom);
      inCfgAddr = 2'($urandom); inCfgData = 17'($urandom); inFifoEmpty = 1'($urandom);
      @(negedge inClock);
      check("reset_hold", pack_out(), 32'd0);
      next_cycle();
    end
    quiet_inputs();
    inReset = 1;
    next_cycle();

    // Directed rotation / config / stop table
    for (int i = 0; i < 33; i++) begin
      inStart = tbl[i].start; inStop = tbl[i].stop; inCfgWrite = tbl[i].wr;
      inCfgAddr = tbl[i].addr; inCfgData = tbl[i].data; inCfgDwell = tbl[i].dwell;
      inLastIdx = 2; inFifoEmpty = 0;
      @(negedge inClock);
      check($sformatf("table_row%0d", i), pack_out(), tbl[i].exp);
      next_cycle();
    end
    quiet_inputs();

    // Asynchronous reset in the middle of a rotation
    inStart = 1; inLastIdx = 2;
    next_cycle();
    inStart = 0;
    repeat (3) next_cycle();
    #2 inReset = 0;
    #1 check("mid_reset_async", pack_out(), 32'd0);
    next_cycle();
    inReset = 1;
    @(negedge inClock);
    check("post_reset_quiet0", pack_out(), 32'd0);
    next_cycle();
    @(negedge inClock);
    check("post_reset_quiet1", pack_out(), 32'd0);
    inStart = 1;
    next_cycle();
    inStart = 0;
    @(negedge inClock);
    check("slots_cleared", pack_out(), mkexp(0,0,1,0,1,0));
    inStop = 1;
    next_cycle();
    inStop = 0;

    // Dwell 4 with empty alternating 1,0,... from the first ACTIVE cycle
    inCfgWrite = 1; inCfgAddr = 0; inCfgData = 17'h00005; inCfgDwell = 4;
    next_cycle();
    inCfgWrite = 0; inLastIdx = 0; inStart = 1;
    next_cycle();
    inStart = 0;
    period = -1;
    for (int k = 0; k < 40; k++) begin
      inFifoEmpty = (k % 2 == 0);
      @(negedge inClock);
      if (k == 0) check("dwell_first_pulse", 32'(outSwitchPulse), 32'd1);
      else if (outSwitchPulse && period < 0) period = k;
      next_cycle();
      if (period >= 0) break;
    end
    check("dwell_switch_period", period, HOLD ? (GUARD_CYCLES + 8) : (GUARD_CYCLES + 4));
    quiet_inputs();
    inStop = 1;
    next_cycle();
    inStop = 0;

    // Randomized run against the reference model
    inReset = 0;
    next_cycle();
    inReset = 1;
    model_reset();
    prev_sel = 0;
    chg_cyc = -100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      inStart     = ($urandom_range(0, 7) == 0);
      inStop      = ($urandom_range(0, 39) == 0);
      inCfgWrite  = ($urandom_range(0, 3) == 0);
      inCfgAddr   = 2'($urandom);
      inCfgData   = 17'($urandom);
      inCfgDwell  = 8'($urandom_range(0, 5));
      inLastIdx   = 2'($urandom);
      inFifoEmpty = ($urandom_range(0, 2) == 0);
      @(negedge inClock);
      check($sformatf("random_cyc%0d", cyc), pack_out(), model_exp());
      if (outSelect != prev_sel) chg_cyc = cyc;
      prev_sel = outSelect;
      if (outReadEnable)
        check($sformatf("break_before_make_cyc%0d", cyc),
              32'(cyc - chg_cyc >= GUARD_CYCLES), 32'd1);
      model_step();
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
